aes_sub_bytes_seq: RTL and testbench



---
 rtl/aes_sub_bytes_seq.sv | 149 ++++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES forward SubBytes engine, BYTES_PER_CYCLE bytes per BUSY cycle.
// Optional round-trip self-check enabled by defining AES_SBOX_ROUNDTRIP_CHECK_EN.
module aes_sub_bytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
  output logic         chk_err,
`endif
  output logic         busy
);

  localparam int unsigned Bpc    = BYTES_PER_CYCLE;
  localparam int unsigned Nchunk = 16 / Bpc;
  localparam int unsigned CntW   = (Nchunk > 1) ? $clog2(Nchunk) : 1;
  localparam int          ChunkW = 8 * Bpc;
  localparam logic [CntW-1:0] LastCnt = CntW'(Nchunk - 1);

  if (Bpc != 1 && Bpc != 2 && Bpc != 4 && Bpc != 8 && Bpc != 16) begin : gen_bpc_illegal
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Entry k of the table sits at bits [2047-8k -: 8].
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTbl[2047 - 8 * int'(b) -: 8];
  endfunction

`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
  localparam logic [2047:0] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTbl[2047 - 8 * int'(b) -: 8];
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [127:0]        work_q, work_d;
  logic [ChunkW-1:0]   cur_chunk;
  logic [ChunkW-1:0]   sub_chunk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StBusy;
      StBusy: if (cnt_q == LastCnt) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
  end

  // Chunk 0 is the most significant ChunkW bits (byte 0 first).
  always_comb begin
    cur_chunk = work_q[127 - int'(cnt_q) * ChunkW -: ChunkW];
    sub_chunk = '0;
    for (int i = 0; i < int'(Bpc); i++) begin
      sub_chunk[ChunkW - 1 - 8 * i -: 8] = sbox(cur_chunk[ChunkW - 1 - 8 * i -: 8]);
    end
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    if (state_q == StIdle && in_valid) begin
      work_d = in_state;
      cnt_d  = '0;
    end else if (state_q == StBusy) begin
      work_d[127 - int'(cnt_q) * ChunkW -: ChunkW] = sub_chunk;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_state = work_q;

`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
  logic chk_mismatch;

  always_comb begin
    chk_mismatch = 1'b0;
    for (int i = 0; i < int'(Bpc); i++) begin
      if (inv_sbox(sub_chunk[ChunkW - 1 - 8 * i -: 8]) != cur_chunk[ChunkW - 1 - 8 * i -: 8]) begin
        chk_mismatch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (state_q == StBusy && chk_mismatch) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq at BYTES_PER_CYCLE = 4, 1 and 16.
// Define AES_SBOX_ROUNDTRIP_CHECK_EN to also exercise the chk_err path.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];
`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
  logic         chk_err   [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]),
`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
    .chk_err(chk_err[0]),
`endif
    .busy(busy[0])
  );

  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]),
`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
    .chk_err(chk_err[1]),
`endif
    .busy(busy[1])
  );

  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]),
`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
    .chk_err(chk_err[2]),
`endif
    .busy(busy[2])
  );

  localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] Zeros   = 128'h0;
  localparam logic [127:0] Z63     = {16{8'h63}};
  localparam logic [127:0] Ones    = {16{8'hff}};
  localparam logic [127:0] F16     = {16{8'h16}};
  localparam logic [127:0] MixIn   = {4{32'h000153ff}};
  localparam logic [127:0] MixOut  = {4{32'h637ced16}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepts one block on DUT d, waits for DONE and checks latency and result.
  task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp,
                      input int nchunk, input bit cmp);
    int lat;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_state[d] = data;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_state[d] = ~data;
    check($sformatf("busy_after_accept%0d", d), 128'(busy[d]), 128'(1));
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[d] && lat < 40);
    if (cmp) begin
      check($sformatf("latency%0d", d), 128'(lat), 128'(nchunk));
      check($sformatf("result%0d", d), out_state[d], exp);
    end
  endtask

  task automatic drain(input int d, input logic [127:0] exp);
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check($sformatf("idle_after_drain%0d", d), 128'(in_ready[d]), 128'(1));
    check($sformatf("out_valid_low%0d", d), 128'(out_valid[d]), 128'(0));
    check($sformatf("out_kept%0d", d), out_state[d], exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_state[i]  = '0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready[0]), 128'(1));
    check("rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("rst_busy", 128'(busy[0]), 128'(0));
    check("rst_out_state", out_state[0], 128'h0);
    rst_n = 1'b1;

    // T2 / T3 on BPC = 4
    send(0, FipsIn, FipsOut, 4, 1'b1);
    drain(0, FipsOut);
    send(0, Zeros, Z63, 4, 1'b1);
    drain(0, Z63);
    send(0, Ones, F16, 4, 1'b1);
    drain(0, F16);
    send(0, MixIn, MixOut, 4, 1'b1);
    drain(0, MixOut);

    // T3 on BPC = 1 and BPC = 16
    send(1, FipsIn, FipsOut, 16, 1'b1);
    drain(1, FipsOut);
    send(1, Zeros, Z63, 16, 1'b1);
    drain(1, Z63);
    send(1, Ones, F16, 16, 1'b1);
    drain(1, F16);
    send(2, FipsIn, FipsOut, 1, 1'b1);
    drain(2, FipsOut);
    send(2, Zeros, Z63, 1, 1'b1);
    drain(2, Z63);
    send(2, Ones, F16, 1, 1'b1);
    drain(2, F16);

    // T4 backpressure with a second block queued during DONE
    send(0, FipsIn, FipsOut, 4, 1'b1);
    in_valid[0] = 1'b1;
    in_state[0] = MixIn;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", out_state[0], FipsOut);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_idle", 128'(in_ready[0]), 128'(1));
    check("bp_not_taken", 128'(busy[0]), 128'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_queued_accept", 128'(busy[0]), 128'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_second_valid", 128'(out_valid[0]), 128'(1));
    check("bp_second_result", out_state[0], MixOut);
    drain(0, MixOut);

    // T5 reset after two chunks
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = FipsIn;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("partial", out_state[0], 128'hd42711aee0bf98f19ac68d2ae9f84808);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_idle", 128'(in_ready[0]), 128'(1));
    check("midrst_state", out_state[0], 128'h0);
    check("midrst_valid", 128'(out_valid[0]), 128'(0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_valid", 128'(out_valid[0]), 128'(0));
    send(0, FipsIn, FipsOut, 4, 1'b1);
    drain(0, FipsOut);

`ifdef AES_SBOX_ROUNDTRIP_CHECK_EN
    // T6 round-trip checker
    for (int n = 0; n < 64; n++) begin
      send(0, {$urandom, $urandom, $urandom, $urandom}, '0, 4, 1'b0);
      drain(0, out_state[0]);
    end
    check("chk_clean", 128'(chk_err[0]), 128'(0));
    force dut0.sub_chunk = '0;
    send(0, FipsIn, FipsOut, 4, 1'b0);
    release dut0.sub_chunk;
    drain(0, out_state[0]);
    check("chk_set", 128'(chk_err[0]), 128'(1));
    send(0, FipsIn, FipsOut, 4, 1'b1);
    drain(0, FipsOut);
    check("chk_sticky", 128'(chk_err[0]), 128'(1));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("chk_cleared", 128'(chk_err[0]), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
